fifo_access_scheduler: RTL and testbench

FIFO_ACCESS_SCHEDULER -- requirements
Module: fifo_access_scheduler

---
 rtl/fifo_access_scheduler.sv | 123 ++++++++++++
 tb/tb_fifo_access_scheduler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fifo_access_scheduler.sv
// fifo_access_scheduler: round-robin arbiter sharing one single-operation
// buffer port between two write producers and one read consumer. Tracks
// buffer occupancy, returns read data one cycle after the read grant and
// flags any write to a full or read from an empty buffer.
module fifo_access_scheduler #(
  parameter int DEPTH = 16,
  parameter int CW    = 5
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          p0_valid,
  input  logic [7:0]    p0_data,
  output logic          p0_ready,
  input  logic          p1_valid,
  input  logic [7:0]    p1_data,
  output logic          p1_ready,
  input  logic          c_req,
  output logic          c_gnt,
  output logic          c_valid,
  output logic [7:0]    c_data,
  output logic          fifo_wr_en,
  output logic          fifo_rd_en,
  output logic [7:0]    fifo_din,
  input  logic [7:0]    fifo_dout,
  input  logic          fifo_full,
  input  logic          fifo_empty,
  output logic [CW-1:0] occupancy,
  output logic          err
);

  typedef enum logic [1:0] {
    GNT_P0 = 2'd0,
    GNT_P1 = 2'd1,
    GNT_RD = 2'd2
  } grant_e;

  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

  grant_e        last_grant_q, last_grant_d;
  logic [CW-1:0] occupancy_q, occupancy_d;
  logic          c_valid_q, c_valid_d;
  logic          err_q, err_d;

  logic el_p0, el_p1, el_rd;
  logic gnt_p0, gnt_p1, gnt_rd;

  // Eligibility and round-robin grant; search begins just after last_grant.
  always_comb begin
    el_p0  = p0_valid && (occupancy_q < DEPTH_W);
    el_p1  = p1_valid && (occupancy_q < DEPTH_W);
    el_rd  = c_req && (occupancy_q != '0);
    gnt_p0 = 1'b0;
    gnt_p1 = 1'b0;
    gnt_rd = 1'b0;
    case (last_grant_q)
      GNT_P0: begin
        if (el_p1)      gnt_p1 = 1'b1;
        else if (el_rd) gnt_rd = 1'b1;
        else if (el_p0) gnt_p0 = 1'b1;
      end
      GNT_P1: begin
        if (el_rd)      gnt_rd = 1'b1;
        else if (el_p0) gnt_p0 = 1'b1;
        else if (el_p1) gnt_p1 = 1'b1;
      end
      default: begin
        if (el_p0)      gnt_p0 = 1'b1;
        else if (el_p1) gnt_p1 = 1'b1;
        else if (el_rd) gnt_rd = 1'b1;
      end
    endcase
  end

  // Next-state: last grant, occupancy, read-data valid and sticky error.
  always_comb begin
    last_grant_d = last_grant_q;
    occupancy_d  = occupancy_q;
    c_valid_d    = gnt_rd;
    err_d        = err_q;
    if (gnt_p0) begin
      last_grant_d = GNT_P0;
      occupancy_d  = occupancy_q + 1'b1;
    end else if (gnt_p1) begin
      last_grant_d = GNT_P1;
      occupancy_d  = occupancy_q + 1'b1;
    end else if (gnt_rd) begin
      last_grant_d = GNT_RD;
      occupancy_d  = occupancy_q - 1'b1;
    end
    if ((fifo_wr_en && fifo_full) || (fifo_rd_en && fifo_empty))
      err_d = 1'b1;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      last_grant_q <= GNT_RD;
      occupancy_q  <= '0;
      c_valid_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      occupancy_q  <= occupancy_d;
      c_valid_q    <= c_valid_d;
      err_q        <= err_d;
    end
  end

  // Output drive: grants, buffer port controls and gated read data.
  always_comb begin
    p0_ready   = gnt_p0;
    p1_ready   = gnt_p1;
    c_gnt      = gnt_rd;
    fifo_wr_en = gnt_p0 | gnt_p1;
    fifo_rd_en = gnt_rd;
    fifo_din   = gnt_p0 ? p0_data : (gnt_p1 ? p1_data : 8'h00);
    c_valid    = c_valid_q;
    c_data     = c_valid_q ? fifo_dout : 8'h00;
    occupancy  = occupancy_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Directed bench for fifo_access_scheduler with a simple buffer model
// supplying registered read data and full/empty status.
module tb_fifo_access_scheduler;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       p0_valid = 1'b0, p1_valid = 1'b0, c_req = 1'b0;
  logic [7:0] p0_data = 8'h00, p1_data = 8'h00;
  logic       p0_ready, p1_ready, c_gnt, c_valid;
  logic [7:0] c_data, fifo_din;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
  logic [4:0] occupancy;
  logic       err;
  logic       force_full = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [16];
  int unsigned wp = 0, rp = 0, cnt = 0;

  fifo_access_scheduler #(.DEPTH(16), .CW(5)) dut (
    .clock(clock), .rst(rst),
    .p0_valid(p0_valid), .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_data(p1_data), .p1_ready(p1_ready),
    .c_req(c_req), .c_gnt(c_gnt), .c_valid(c_valid), .c_data(c_data),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_din(fifo_din),
    .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .occupancy(occupancy), .err(err)
  );

  always #5 clock = ~clock;

  assign fifo_full  = force_full | (cnt == 16);
  assign fifo_empty = (cnt == 0);

  // Buffer model: registered read data, wrap-around pointers.
  always @(posedge clock) begin
    if (rst) begin
      wp  <= 0;
      rp  <= 0;
      cnt <= 0;
    end else begin
      if (fifo_wr_en && cnt < 16) begin
        mem[wp] <= fifo_din;
        wp      <= (wp + 1) % 16;
        cnt     <= cnt + 1;
      end else if (fifo_rd_en && cnt > 0) begin
        fifo_dout <= mem[rp];
        rp        <= (rp + 1) % 16;
        cnt       <= cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, settle, then the caller checks.
  task automatic step(input logic a, input logic [7:0] ad, input logic b,
                      input logic [7:0] bd, input logic r);
    @(negedge clock);
    p0_valid = a; p0_data = ad;
    p1_valid = b; p1_data = bd;
    c_req    = r;
    #2;
  endtask

  task automatic grants(input string tag, input logic e0, input logic e1, input logic er);
    chk({tag, "_p0_ready"}, p0_ready, e0);
    chk({tag, "_p1_ready"}, p1_ready, e1);
    chk({tag, "_c_gnt"}, c_gnt, er);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b1;
    p0_valid = 1'b0; p1_valid = 1'b0; c_req = 1'b0;
    @(negedge clock);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    step(0, 8'h00, 0, 8'h00, 0);
    rst = 1'b0;
    #1;
    chk("rst_occ", occupancy, 0);
    chk("rst_cvalid", c_valid, 0);
    chk("rst_cdata", c_data, 8'h00);
    chk("rst_err", err, 0);
    chk("rst_din", fifo_din, 8'h00);

    // Two producers alternate, P0 first
    step(1, 8'h10, 1, 8'h20, 0); grants("w1", 1, 0, 0); chk("w1_din", fifo_din, 8'h10);
    step(1, 8'h11, 1, 8'h21, 0); grants("w2", 0, 1, 0); chk("w2_din", fifo_din, 8'h21);
    step(1, 8'h12, 1, 8'h22, 0); grants("w3", 1, 0, 0); chk("w3_wr", fifo_wr_en, 1);
    step(1, 8'h13, 1, 8'h23, 0); grants("w4", 0, 1, 0); chk("w4_din", fifo_din, 8'h23);
    step(0, 8'h00, 0, 8'h00, 0); chk("w_occ", occupancy, 4); chk("w_idle_wr", fifo_wr_en, 0);

    // Preload two words then drain them
    do_reset();
    step(1, 8'hA1, 0, 8'h00, 0); grants("pl1", 1, 0, 0);
    step(1, 8'hB2, 0, 8'h00, 0); grants("pl2", 1, 0, 0);
    step(0, 8'h00, 0, 8'h00, 1); grants("rd1", 0, 0, 1); chk("rd1_rden", fifo_rd_en, 1);
    chk("rd1_occ", occupancy, 2);
    step(0, 8'h00, 0, 8'h00, 1); grants("rd2", 0, 0, 1);
    chk("rd2_cvalid", c_valid, 1); chk("rd2_cdata", c_data, 8'hA1);
    step(0, 8'h00, 0, 8'h00, 1); grants("rd3", 0, 0, 0); chk("rd3_rden", fifo_rd_en, 0);
    chk("rd3_cdata", c_data, 8'hB2); chk("rd3_occ", occupancy, 0);
    step(0, 8'h00, 0, 8'h00, 0);
    chk("rd4_cvalid", c_valid, 0); chk("rd4_cdata", c_data, 8'h00);

    // Reach occupancy 5 with last grant on the read side
    for (int i = 0; i < 6; i++) begin
      step(1, 8'(8'h30 + i), 0, 8'h00, 0); grants("pre5", 1, 0, 0);
    end
    step(0, 8'h00, 0, 8'h00, 1); grants("pre5_rd", 0, 0, 1);
    step(0, 8'h00, 0, 8'h00, 0); chk("pre5_occ", occupancy, 5);

    // All three eligible: P0,P1,RD,P0,P1,RD
    step(1, 8'h40, 1, 8'h50, 1); grants("rr1", 1, 0, 0);
    step(1, 8'h41, 1, 8'h51, 1); grants("rr2", 0, 1, 0);
    step(1, 8'h42, 1, 8'h52, 1); grants("rr3", 0, 0, 1);
    step(1, 8'h43, 1, 8'h53, 1); grants("rr4", 1, 0, 0);
    step(1, 8'h44, 1, 8'h54, 1); grants("rr5", 0, 1, 0);
    step(1, 8'h45, 1, 8'h55, 1); grants("rr6", 0, 0, 1);
    step(0, 8'h00, 0, 8'h00, 0); chk("rr_occ", occupancy, 7);

    // Fill to DEPTH, then read while full
    for (int i = 0; i < 9; i++) begin
      step(1, 8'(8'h60 + i), 0, 8'h00, 0); grants("fill", 1, 0, 0);
    end
    step(1, 8'h70, 0, 8'h00, 1); grants("full_rd", 0, 0, 1); chk("full_occ", occupancy, 16);
    step(1, 8'h71, 0, 8'h00, 1); grants("full_p0", 1, 0, 0); chk("full_occ15", occupancy, 15);
    step(1, 8'h72, 1, 8'h82, 0); grants("full_block", 0, 0, 0);
    chk("full_occ16", occupancy, 16); chk("full_wr", fifo_wr_en, 0);
    step(0, 8'h00, 0, 8'h00, 0); chk("full_hold", occupancy, 16); chk("full_err", err, 0);

    // Error flag on write to a full buffer
    do_reset();
    force_full = 1'b1;
    step(1, 8'h99, 0, 8'h00, 0); grants("err_w", 1, 0, 0); chk("err_before", err, 0);
    step(0, 8'h00, 0, 8'h00, 0);
    force_full = 1'b0;
    #1;
    chk("err_set", err, 1);
    step(0, 8'h00, 0, 8'h00, 0); step(0, 8'h00, 0, 8'h00, 0);
    chk("err_sticky", err, 1);
    do_reset();
    step(0, 8'h00, 0, 8'h00, 0); chk("err_clr", err, 0);

    // Reset right after a read grant
    step(1, 8'hC3, 0, 8'h00, 0); grants("r44_w", 1, 0, 0);
    step(0, 8'h00, 0, 8'h00, 1); grants("r44_rd", 0, 0, 1);
    @(negedge clock);
    rst = 1'b1;
    p0_valid = 1'b0; p1_valid = 1'b0; c_req = 1'b0;
    #2;
    chk("r44_cvalid_pre", c_valid, 1); chk("r44_cdata_pre", c_data, 8'hC3);
    @(negedge clock);
    rst = 1'b0;
    #1;
    chk("r44_cvalid", c_valid, 0); chk("r44_occ", occupancy, 0);
    step(1, 8'hD0, 1, 8'hE0, 1); grants("r44_next", 1, 0, 0);
    chk("r44_din", fifo_din, 8'hD0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
